// File: rtl/sect_pt_mul_host.sv
`default_nettype none
// ============================================================================
// Module  : sect_pt_mul_host
// Brief   : Word-serial host adapter for a sect_pt_mul point-multiply core.
// Revision: 1.0
// ============================================================================
module sect_pt_mul_host #(
    parameter int M  = 571,
    parameter int W  = 32,
    parameter int NW = (M + W - 1) / W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         pm_start,
    output logic [M-1:0] pm_d,
    input  logic         pm_done,
    input  logic [M-1:0] pm_x,
    input  logic [M-1:0] pm_y
);

    localparam int c_CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int c_WB = (W > 1) ? $clog2(W) : 1;
    localparam int c_MB = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NW - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT_X = 3'd3,
        S_OUT_Y = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nx;
    logic [M-1:0]    r_d;
    logic [M-1:0]    w_d_nx;
    logic [M-1:0]    r_x;
    logic [M-1:0]    r_y;
    logic [M-1:0]    w_src;
    logic            w_cap;
    logic            w_cnt_last;

    assign w_cnt_last = (r_cnt == c_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_d_nx     = r_d;
        w_cap      = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (in_valid) begin
                    // Only bits below M are written, so the top word's excess is dropped.
                    for (int i = 0; i < M; i++) begin
                        if ((i / W) == int'(r_cnt)) begin
                            w_d_nx[i] = in_data[c_WB'(i % W)];
                        end
                    end
                    if (w_cnt_last) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_START;
                    end else begin
                        w_cnt_nx = r_cnt + c_CW'(1);
                    end
                end
            end
            S_START: w_state_nx = S_WAIT;
            S_WAIT: begin
                if (pm_done) begin
                    w_cap      = 1'b1;
                    w_state_nx = S_OUT_X;
                end
            end
            S_OUT_X, S_OUT_Y: begin
                if (out_ready) begin
                    if (w_cnt_last) begin
                        w_cnt_nx   = '0;
                        w_state_nx = (r_state == S_OUT_X) ? S_OUT_Y : S_LOAD;
                    end else begin
                        w_cnt_nx = r_cnt + c_CW'(1);
                    end
                end
            end
            default: w_state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_d     <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (clr) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_d     <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_d     <= w_d_nx;
            if (w_cap) begin
                r_x <= pm_x;
                r_y <= pm_y;
            end
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign pm_start  = (r_state == S_START);
    assign pm_d      = r_d;
    assign out_valid = (r_state == S_OUT_X) || (r_state == S_OUT_Y);
    assign out_last  = (r_state == S_OUT_Y) && w_cnt_last;
    assign w_src     = (r_state == S_OUT_Y) ? r_y : r_x;

    // Word select with zero padding above bit M-1 of the top word.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < W; j++) begin
                if ((int'(r_cnt) * W + j) < M) begin
                    out_data[j] = w_src[c_MB'(int'(r_cnt) * W + j)];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sect_pt_mul_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_sect_pt_mul_host
// Brief   : Self-checking bench for sect_pt_mul_host with a stub core.
// Revision: 1.0
// ============================================================================
module tb_sect_pt_mul_host;

    localparam int M  = 571;
    localparam int W  = 32;
    localparam int NW = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         pm_start;
    logic [M-1:0] pm_d;
    logic         pm_done;
    logic [M-1:0] pm_x;
    logic [M-1:0] pm_y;

    logic [M-1:0] stub_d    = '0;
    int           stub_ct   = 0;
    logic         stub_done = 1'b0;
    logic         force_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] w0, wrest;
        logic [W-1:0] x0, xmid, xtop;
        logic [W-1:0] y0, ymid, ytop;
    } vec_t;

    vec_t vt[3];

    sect_pt_mul_host #(.M(M), .W(W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy),
        .pm_start(pm_start), .pm_d(pm_d), .pm_done(pm_done),
        .pm_x(pm_x), .pm_y(pm_y)
    );

    always #5 clk = ~clk;

    // Stub core: done pulse 10 cycles after start, x = ~d, y = d.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (pm_start) begin
            stub_ct <= 9;
            stub_d  <= pm_d;
        end else if (stub_ct != 0) begin
            stub_ct   <= stub_ct - 1;
            stub_done <= (stub_ct == 1);
        end
    end
    assign pm_done = stub_done | force_done;
    assign pm_x    = ~stub_d;
    assign pm_y    = stub_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NW*W-1:0] build(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
        logic [NW*W-1:0] r;
        for (int k = 0; k < NW; k++)
            r[k*W +: W] = (k == 0) ? a : ((k == NW-1) ? c : b);
        return r;
    endfunction

    task automatic model(input logic [NW*W-1:0] words, output logic [NW*W-1:0] ex,
                         output logic [NW*W-1:0] ey);
        logic [M-1:0] dm;
        logic [M-1:0] nd;
        dm = words[M-1:0];
        nd = ~dm;
        ex = '0;
        ey = '0;
        ex[M-1:0] = nd;
        ey[M-1:0] = dm;
    endtask

    task automatic send(input logic [NW*W-1:0] words, input bit rnd, input bit spur);
        int k   = 0;
        int cyc = 0;
        while (k < NW && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = words[k*W +: W];
                if (in_ready) k++;
            end
        end
        if (k < NW) chk("load_timeout", 64'(k), 64'(NW));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        chk("pm_start_pulse", 64'(pm_start), 64'd1);
        chk("in_ready_start", 64'(in_ready), 64'd0);
        if (spur) force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        chk("pm_start_single", 64'(pm_start), 64'd0);
        chk("busy_wait", 64'(busy), 64'd1);
    endtask

    task automatic check_pmd(input logic [NW*W-1:0] ey);
        logic [NW*W-1:0] pd;
        pd = '0;
        pd[M-1:0] = pm_d;
        for (int k = 0; k < NW; k++) chk("pm_d_word", 64'(pd[k*W +: W]), 64'(ey[k*W +: W]));
    endtask

    task automatic receive(input logic [NW*W-1:0] ex, input logic [NW*W-1:0] ey, input bit rnd,
                           input int stop, input int exp_wait);
        int got = 0, cyc = 0, waited = 0, first = -1, lastc = 0;
        bit rdy, stalled = 1'b0;
        logic [W-1:0] prev = '0, expw;
        while (got < stop && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (!out_valid) begin
                if (first < 0) waited++;
                chk("busy_pre_out", 64'(busy), 64'd1);
            end else begin
                if (first < 0) first = cyc;
                expw = (got < NW) ? ex[got*W +: W] : ey[(got-NW)*W +: W];
                chk("out_data", 64'(out_data), 64'(expw));
                chk("out_last", 64'(out_last), 64'(got == 2*NW-1));
                chk("busy_out", 64'(busy), 64'd1);
                if (stalled) chk("stall_hold", 64'(out_data), 64'(prev));
                stalled = !rdy;
                prev    = out_data;
                if (rdy) begin
                    got++;
                    lastc = cyc;
                end
            end
        end
        if (got < stop) chk("out_timeout", 64'(got), 64'(stop));
        if (exp_wait >= 0) chk("valid_latency", 64'(waited), 64'(exp_wait));
        if (!rnd && stop == 2*NW) chk("b2b_span", 64'(lastc - first), 64'(2*NW-1));
        if (stop == 2*NW) begin
            @(negedge clk);
            out_ready = 1'b0;
            chk("idle_after_job", {62'd0, in_ready, out_valid}, 64'b10);
        end
    endtask

    initial begin
        logic [NW*W-1:0] wr, ex, ey;

        vt[0] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h07FFFFFF,
                  32'h00000001, 32'h00000000, 32'h00000000};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h07FFFFFF};
        vt[2] = '{32'h12345678, 32'hA5A5A5A5, 32'hEDCBA987, 32'h5A5A5A5A, 32'h025A5A5A,
                  32'h12345678, 32'hA5A5A5A5, 32'h05A5A5A5};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; force_done = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pm_start", 64'(pm_start), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_pm_d_zero", 64'(pm_d == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                force_done = 1'b1;
                @(negedge clk);
                force_done = 1'b0;
                chk("done_in_load_ignored", {62'd0, in_ready, busy}, 64'b10);
            end
            send(build(vt[i].w0, vt[i].wrest, vt[i].wrest), 1'b0, i == 2);
            check_pmd(build(vt[i].y0, vt[i].ymid, vt[i].ytop));
            receive(build(vt[i].x0, vt[i].xmid, vt[i].xtop),
                    build(vt[i].y0, vt[i].ymid, vt[i].ytop), 1'b0, 2*NW, 9);
        end

        // Random input gaps and output stalls.
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < NW; k++) wr[k*W +: W] = $urandom;
            model(wr, ex, ey);
            send(wr, 1'b1, 1'b0);
            check_pmd(ey);
            receive(ex, ey, 1'b1, 2*NW, 9);
        end

        // Synchronous clear during WAIT; the stale done must be ignored.
        send(build(32'hCAFEF00D, 32'h0, 32'h0), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_state", {61'd0, in_ready, busy, out_valid}, 64'b100);
        chk("clr_pm_d_zero", 64'(pm_d == '0), 64'd1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("stale_done_ignored", {62'd0, in_ready, out_valid}, 64'b10);
        end
        for (int k = 0; k < NW; k++) wr[k*W +: W] = $urandom;
        model(wr, ex, ey);
        send(wr, 1'b0, 1'b0);
        receive(ex, ey, 1'b0, 2*NW, 9);

        // Asynchronous reset in the middle of OUT_X.
        send(wr, 1'b0, 1'b0);
        receive(ex, ey, 1'b0, 5, 9);
        #2 rst = 1'b1;
        #1;
        chk("arst_outputs", {59'd0, out_valid, out_last, busy, pm_start, in_ready}, 64'b00001);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NW; k++) wr[k*W +: W] = $urandom;
        model(wr, ex, ey);
        send(wr, 1'b0, 1'b0);
        check_pmd(ey);
        receive(ex, ey, 1'b0, 2*NW, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sect_pt_mul_host.md
Name: sect_pt_mul_host

Overview:
- Host-side word-serial adapter that drives the start/d/done/x/y handshake of a sect_pt_mul-style point-multiplication core.
- Accepts the scalar d as a stream of W-bit words and assembles it into an M-bit register.
- Issues a one-cycle start pulse to the core, waits for done, captures x and y, then streams them back out as W-bit words.
- Sits between a narrow bus or stream fabric and any sect*_pt_mul wrapper.

Parameters:
- M, 571, field degree; width of d, x and y.
- W, 32, stream word width.
- NW, (M+W-1)/W (= 18 at defaults), number of words per M-bit operand. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- clr  in  1  synchronous clear.
- in_valid  in  1  scalar word valid.
- in_ready  out  1  scalar word accepted when in_valid && in_ready.
- in_data  in  W  scalar word, least-significant word first.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts a result word.
- out_data  out  W  result word.
- out_last  out  1  high on the final result word (y, word NW-1).
- busy  out  1  high in every state except LOAD.
- pm_start  out  1  one-cycle start pulse to the core.
- pm_d  out  M  scalar to the core; held stable from pm_start until the core signals done.
- pm_done  in  1  core computation done.
- pm_x  in  M  core result x.
- pm_y  in  M  core result y.

Behaviour:
- States: LOAD, START, WAIT, OUT_X, OUT_Y.
- rst (asynchronous) and clr (synchronous, priority over all other activity) both force:
  - state to LOAD;
  - word counter, d register, x register and y register to 0;
  - pm_start, out_valid, out_last and busy to 0;
  - out_data to 0.
- in_ready = (state==LOAD). It is therefore 1 during and after reset.
- LOAD:
  - Each accepted word k (0..NW-1) is written to d[k*W +: W].
  - Bits of the final word at positions >= M are discarded.
  - Acceptance of word NW-1 moves the state to START. The counter wraps to 0.
- START: pm_start = 1 for exactly one cycle, then the state moves to WAIT.
  - Latency: last scalar word accepted in cycle N gives pm_start high in cycle N+1 and WAIT from cycle N+2.
- WAIT:
  - On the first cycle with pm_done=1, capture pm_x and pm_y and go to OUT_X.
  - pm_done in any other state is ignored. pm_done in the same cycle as pm_start is ignored.
  - No timeout.
- OUT_X:
  - out_valid = 1 starting the cycle after capture.
  - out_data = x[k*W +: W] for k = 0..NW-1, with bits above M-1 of the top word zero-padded.
  - The index advances only on out_valid && out_ready.
  - out_data is held stable while out_valid && !out_ready.
  - After word NW-1 transfers, go to OUT_Y.
- OUT_Y:
  - Same word ordering and padding as OUT_X, applied to y.
  - out_last = 1 only on word NW-1.
  - When that word transfers, go to LOAD with out_valid = 0 in the next cycle.
- Back-to-back output: with out_ready held at 1, one word transfers per cycle, so 2*NW transfers occur in 2*NW consecutive cycles.
- pm_d is a direct drive from the d register. It is stable through START and WAIT because loading is blocked.
- clr or rst mid-operation abandons the current job. Any later pm_done is ignored until a new job reaches WAIT.
- in_valid outside LOAD has no effect, since in_ready = 0.

Test Plan:
1. Bench uses a stub core that asserts pm_done 10 cycles after pm_start with pm_x=~pm_d, pm_y=pm_d.
   - Load 18 words 0x00000001, 0, ..., 0, then hold out_ready=1.
   - Required: pm_start single pulse in the cycle after word 17 is accepted; pm_d = 571'h1.
   - Output words 0-17 are x: word 0 = 0xFFFFFFFE, words 1-16 = 0xFFFFFFFF, word 17 = 0x07FFFFFF.
   - Output words 18-35 are y: word 18 = 0x00000001, rest 0; out_last only on word 35.
2. Load 18 words of 0xFFFFFFFF.
   - Required: pm_d = all-ones over 571 bits; y output word 17 = 0x07FFFFFF, showing discarded upper input bits.
3. Load words with in_valid toggling randomly; stall out_ready randomly (about 50%).
   - Required: every transfer matches the reference model; out_data is unchanged across stall cycles; busy stays 1 from START until the last output transfer.
4. Pulse pm_done while in LOAD and again during the same cycle as pm_start.
   - Required: both are ignored; the job completes only on the stub's real done.
5. Assert clr for one cycle during WAIT, then let the stub's done arrive.
   - Required: state returns to LOAD, in_ready = 1, out_valid stays 0, and the stale done is ignored.
   - A new job then completes correctly.
6. Assert rst asynchronously mid-OUT_X.
   - Required: out_valid, out_last, busy and pm_start go to 0 immediately without waiting for a clock edge; in_ready = 1; the next full job is correct.
